fact_seq_ctrl: RTL and testbench
================================

Name: fact_seq_ctrl

Overview:
- Multi-cycle sequenced version of the team's combinational n*n!/(2n+1) datapath.
- Uses one shared 32-bit multiplier for the factorial and scale steps, and one restoring divider at one quotient bit per cycle.
- Start/done handshake, so it sits behind a bus or host FSM and replaces the single-cycle multiply/divide chain in timing-critical builds.
- Arithmetic results are bit-identical to the combinational function: every product is truncated to 32 bits.

Parameters:
- NW, 4, width of operand n.
- RW, 32, width of accumulator, quotient and result.
- DIV_CYCLES, RW (32), number of divider iterations; not to be overridden independently of RW.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request. Sampled only in IDLE; ignored otherwise.
- n  input  NW  operand, captured on the cycle start is accepted.
- busy  output  1  high in every state except IDLE.
- done  output  1  single-cycle pulse when result updates.
- result  output  RW  last completed result; holds until the next done.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; busy=0, done=0, result=0; all internal registers cleared.
  - Reset asserted mid-operation aborts the computation; result returns to 0.
- IDLE:
  - On start=1: n_q<=n; acc<=(n!=0)?1:0; idx<=2; go to FACT.
- FACT:
  - Each cycle, if idx<=n_q: acc<=acc*idx (low RW bits), idx<=idx+1.
  - If idx>=n_q: go to SCALE.
  - FACT lasts F=max(n-1,1) cycles. n=0 and n=1 perform no multiply.
  - idx is NW+1 bits wide, so n=15 terminates without wrapping.
- SCALE:
  - acc<=acc*n_q (low RW bits).
  - div<=2*n_q+1, zero-extended; range 1..31, never zero.
  - Go to DIV.
- DIV:
  - Restoring division of acc by div, MSB first, one quotient bit per cycle, DIV_CYCLES cycles.
  - Then go to DONE.
- DONE:
  - result<=quotient; done=1 for exactly this cycle; next state IDLE.
- Latency:
  - start accepted at edge k → done high in the cycle after edge k+F+1+DIV_CYCLES.
  - n=5: done 38 cycles after acceptance. n=0,1: 35 cycles.
- Back-to-back:
  - start in the DONE cycle is ignored, because busy=1.
  - A new request is accepted the cycle after done (minimum spacing = latency+1).
- Inputs:
  - start held high continuously restarts immediately on each return to IDLE.
  - n changing while busy has no effect.

Optional Feature:
- Macro: FACT_SEQ_OVF_EN.
- When defined:
  - Extra output ovf (1 bit).
  - Cleared in IDLE on start acceptance.
  - Set if any FACT or SCALE product has nonzero bits above RW (2*RW-bit product check).
  - Valid with done and held with result; reset value 0.
- When undefined: no ovf port, and no wide-product logic is synthesized.

Decomposition:
- Package fact_seq_pkg:
  - State enum {IDLE, FACT, SCALE, DIV, DONE}.
  - Width constants NW, RW, DIV_CYCLES.
  - Function returning 2n+1.
- One sub-module: seq_divider. Restoring RW-bit divider with start/busy/done and quotient/remainder outputs, instantiated in the DIV phase.
- Multiplier stays inline, shared by FACT and SCALE through a mux.

Test Plan:
- reset low during power-up, then start with n=5 → busy rises next cycle; done pulses 38 cycles after acceptance; result=54 (600/11).
- n=0, then n=1, then n=3 back-to-back, each start issued the cycle after done → results 0, 0, 2; each done is exactly one cycle wide.
- n=12 → result=58122076 (12*12! mod 2^32 = 1453051904, /25). With FACT_SEQ_OVF_EN: ovf=1. Repeat with n=5 → ovf=0.
- n=15 → result=138543434 (4294846464/31); no hang (idx exceeds 15 cleanly).
- start pulsed, then reset driven low for 1 cycle during DIV → outputs immediately 0 and state IDLE; no done afterward until a new start; a following n=5 request yields 54.
- start held high throughout, n toggled while busy → only the n captured at each acceptance is used; start during DONE does not extend or corrupt the pulse.

Source files
------------

// File: rtl/fact_seq_pkg.sv
// fact_seq_pkg: shared widths, FSM state encoding and divisor helper for the
// sequenced n*n!/(2n+1) controller.
package fact_seq_pkg;

    localparam int NW         = 4;
    localparam int RW         = 32;
    localparam int DIV_CYCLES = RW;

    typedef enum logic [2:0] {
        IDLE,
        FACT,
        SCALE,
        DIV,
        DONE
    } state_t;

    // Returns 2n+1 zero-extended to RW bits; never zero for any n.
    function automatic logic [RW-1:0] odd_divisor(input logic [NW-1:0] n);
        logic [RW-1:0] d;
        d       = '0;
        d[NW:0] = {n, 1'b1};
        return d;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring W-bit unsigned divider, one quotient bit per clock,
// MSB first. The first quotient bit is produced on the start edge itself, so a
// full division occupies exactly W clock edges and done is high during the
// cycle that follows the final step.
module seq_divider #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  divisor_q;
    logic [W-1:0]  rem_q;
    logic [W-1:0]  quo_q;
    logic [CW-1:0] count;

    logic [W-1:0]  rem_in;
    logic [W-1:0]  quo_in;
    logic [W-1:0]  div_in;
    logic [W:0]    trial;
    logic [W:0]    diff;
    logic          fits;
    logic [W-1:0]  rem_next;
    logic [W-1:0]  quo_next;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits; a new request starts
    // from a zero remainder with the fresh operands.
    always_comb begin
        rem_in = rem_q;
        quo_in = quo_q;
        div_in = divisor_q;
        if (start && !busy) begin
            rem_in = '0;
            quo_in = dividend;
            div_in = divisor;
        end
        trial    = {rem_in, quo_in[W-1]};
        diff     = trial - {1'b0, div_in};
        fits     = (trial >= {1'b0, div_in});
        rem_next = fits ? diff[W-1:0] : trial[W-1:0];
        quo_next = {quo_in[W-2:0], fits};
    end

    // Iteration register: loads and takes the first step on start, then runs
    // the remaining W-1 steps and raises done for one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                divisor_q <= divisor;
                rem_q     <= rem_next;
                quo_q     <= quo_next;
                count     <= CW'(W - 1);
                busy      <= 1'b1;
            end else if (busy) begin
                rem_q <= rem_next;
                quo_q <= quo_next;
                count <= count - CW'(1);
                if (count == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/fact_seq_ctrl.sv
// fact_seq_ctrl: multi-cycle n*n!/(2n+1) with a start/done handshake.
// One shared RW-bit multiplier serves the factorial and scale steps; a
// restoring divider produces one quotient bit per cycle. Every product is
// truncated to RW bits, matching the combinational datapath exactly.
// Optional: define FACT_SEQ_OVF_EN to add the ovf output, which flags any
// factorial or scale product that lost bits above RW.
module fact_seq_ctrl
    import fact_seq_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [NW-1:0] n,
    output logic          busy,
    output logic          done,
    output logic [RW-1:0] result
`ifdef FACT_SEQ_OVF_EN
    ,
    output logic          ovf
`endif
);

    localparam logic [NW:0]   IDX_FIRST = 2;
    localparam logic [RW-1:0] ACC_ONE   = 1;

    state_t         state;
    logic [NW-1:0]  n_q;
    logic [NW:0]    idx;
    logic [RW-1:0]  acc;

    logic [RW-1:0]  mult_b;
    logic [RW-1:0]  prod;
    logic           fact_step;
    logic           fact_last;
    logic           div_start;
    logic           div_busy;
    logic           div_done;
    logic [RW-1:0]  div_quotient;
    logic [RW-1:0]  div_remainder;
    logic           div_unused;

    // Shared multiplier operand: the scale step multiplies by n, every
    // factorial step multiplies by the running index.
    always_comb begin
        mult_b = '0;
        if (state == SCALE) begin
            mult_b[NW-1:0] = n_q;
        end else begin
            mult_b[NW:0] = idx;
        end
    end

`ifdef FACT_SEQ_OVF_EN
    logic [2*RW-1:0] prod_wide;
    logic            prod_ovf;
    assign prod_wide = {{RW{1'b0}}, acc} * {{RW{1'b0}}, mult_b};
    assign prod      = prod_wide[RW-1:0];
    assign prod_ovf  = |prod_wide[2*RW-1:RW];
`else
    assign prod = acc * mult_b;
`endif

    assign fact_step = (idx <= {1'b0, n_q});
    assign fact_last = (idx >= {1'b0, n_q});
    assign div_start = (state == SCALE);

    // The divider takes the scaled product straight off the multiplier so its
    // first quotient bit lands on the SCALE edge and DIV lasts DIV_CYCLES.
    seq_divider #(
        .W (RW)
    ) u_divider (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (prod),
        .divisor   (odd_divisor(n_q)),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    // Remainder and divider busy are not needed by this controller.
    assign div_unused = div_busy ^ (^div_remainder);

    // Sequencer: captures n on start, walks the factorial, scales, waits for
    // the divider and publishes the quotient with a one-cycle done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            n_q    <= '0;
            idx    <= '0;
            acc    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
`ifdef FACT_SEQ_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_q   <= n;
                        acc   <= (n != '0) ? ACC_ONE : '0;
                        idx   <= IDX_FIRST;
                        busy  <= 1'b1;
                        state <= FACT;
`ifdef FACT_SEQ_OVF_EN
                        ovf   <= 1'b0;
`endif
                    end
                end
                FACT: begin
                    if (fact_step) begin
                        acc <= prod;
                        idx <= idx + 1'b1;
`ifdef FACT_SEQ_OVF_EN
                        if (prod_ovf) begin
                            ovf <= 1'b1;
                        end
`endif
                    end
                    if (fact_last) begin
                        state <= SCALE;
                    end
                end
                SCALE: begin
                    acc   <= prod;
                    state <= DIV;
`ifdef FACT_SEQ_OVF_EN
                    if (prod_ovf) begin
                        ovf <= 1'b1;
                    end
`endif
                end
                DIV: begin
                    if (div_done) begin
                        result <= div_quotient;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fact_seq_ctrl.sv
// tb_fact_seq_ctrl: table-driven and hand-sequenced checks of fact_seq_ctrl
// with a queue scoreboard of expected results, ovf flags and latencies.
// Define FACT_SEQ_OVF_EN to also check the ovf output.
module tb_fact_seq_ctrl;
    import fact_seq_pkg::*;

    typedef struct {
        logic [NW-1:0] n;
        logic [RW-1:0] res;
        logic          ovf;
        int            lat;
        int            acc_cyc;
    } exp_t;

    typedef struct {
        logic [NW-1:0] n;
        logic [RW-1:0] res;
        logic          ovf;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [NW-1:0] n_in;
    logic          busy;
    logic          done;
    logic [RW-1:0] result;
`ifdef FACT_SEQ_OVF_EN
    logic          ovf;
`endif

    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    vec_t vecs[10];

    fact_seq_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .n      (n_in),
        .busy   (busy),
        .done   (done),
        .result (result)
`ifdef FACT_SEQ_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    // Free-running clock and cycle counter used for latency measurement.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int latency_of(input logic [NW-1:0] v);
        int f;
        f = (v > 1) ? int'(v) - 1 : 1;
        return f + 1 + DIV_CYCLES;
    endfunction

    // Reference arithmetic: truncating factorial and scale, then divide.
    function automatic void model(input logic [NW-1:0] v,
                                  output logic [RW-1:0] res,
                                  output logic ov);
        logic [2*RW-1:0] w;
        logic [RW-1:0]   a;
        logic [RW-1:0]   d;
        a  = (v != 0) ? 1 : 0;
        ov = 1'b0;
        for (int i = 2; i <= int'(v); i++) begin
            w  = 64'(a) * 64'(i);
            ov = ov | (w[2*RW-1:RW] != 0);
            a  = w[RW-1:0];
        end
        w   = 64'(a) * 64'(v);
        ov  = ov | (w[2*RW-1:RW] != 0);
        a   = w[RW-1:0];
        d   = RW'(v) * 2 + 1;
        res = a / d;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Compare the DUT's completed result against the oldest scoreboard entry.
    task automatic score_done();
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected done: got done with result %0d, expected no done", result);
        end else begin
            e = sb.pop_front();
            checkOutput($sformatf("result n=%0d", e.n), 64'(result), 64'(e.res));
            checkOutput($sformatf("latency n=%0d", e.n), 64'(cyc - e.acc_cyc), 64'(e.lat));
`ifdef FACT_SEQ_OVF_EN
            checkOutput($sformatf("ovf n=%0d", e.n), 64'(ovf), 64'(e.ovf));
`endif
        end
    endtask

    // Called at a negedge with the DUT idle: request one operation, then
    // scramble n while busy to show the captured value is the one used.
    task automatic applyStimulus(input logic [NW-1:0] v, input logic [RW-1:0] r,
                                 input logic o);
        start = 1'b1;
        n_in  = v;
        @(negedge clk);
        start = 1'b0;
        n_in  = ~v;
        sb.push_back('{n: v, res: r, ovf: o, lat: latency_of(v), acc_cyc: cyc});
        checkOutput($sformatf("busy after accept n=%0d", v), 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                score_done();
                seen = 1'b1;
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("[TB] FAIL timeout: got no done, expected done within %0d cycles", budget);
        end
        @(negedge clk);
        checkOutput("done one cycle wide", 64'(done), 64'd0);
        checkOutput("idle after done", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [RW-1:0] r;
        logic          o;
        logic [NW-1:0] v;
        int            stray;
        int            got;
        bit            prev_done;

        vecs[0] = '{n: 4'd0,  res: 32'd0,         ovf: 1'b0};
        vecs[1] = '{n: 4'd1,  res: 32'd0,         ovf: 1'b0};
        vecs[2] = '{n: 4'd3,  res: 32'd2,         ovf: 1'b0};
        vecs[3] = '{n: 4'd5,  res: 32'd54,        ovf: 1'b0};
        vecs[4] = '{n: 4'd12, res: 32'd58122076,  ovf: 1'b1};
        vecs[5] = '{n: 4'd5,  res: 32'd54,        ovf: 1'b0};
        vecs[6] = '{n: 4'd15, res: 32'd138543434, ovf: 1'b1};
        vecs[7] = '{n: 4'd2,  res: 32'd0,         ovf: 1'b0};
        vecs[8] = '{n: 4'd7,  res: 32'd2352,      ovf: 1'b0};
        vecs[9] = '{n: 4'd10, res: 32'd1728000,   ovf: 1'b0};

        reset = 1'b0;
        start = 1'b0;
        n_in  = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset result", 64'(result), 64'd0);
`ifdef FACT_SEQ_OVF_EN
        checkOutput("reset ovf", 64'(ovf), 64'd0);
`endif
        reset = 1'b1;
        @(negedge clk);

        // Power-up request with n=5 first, then the table back-to-back.
        applyStimulus(4'd5, 32'd54, 1'b0);
        wait_done(200);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(vecs[k].n, vecs[k].res, vecs[k].ovf);
            wait_done(200);
        end

        // A few random operands against the reference model.
        for (int k = 0; k < 4; k++) begin
            v = NW'($urandom_range(0, 15));
            model(v, r, o);
            applyStimulus(v, r, o);
            wait_done(200);
        end

        // Abort during DIV with a one-cycle reset pulse.
        applyStimulus(4'd5, 32'd54, 1'b0);
        repeat (15) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort done", 64'(done), 64'd0);
        checkOutput("abort result", 64'(result), 64'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        stray = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) stray++;
        end
        checkOutput("no done after abort", 64'(stray), 64'd0);
        checkOutput("idle after abort", 64'(busy), 64'd0);
        applyStimulus(4'd5, 32'd54, 1'b0);
        wait_done(200);

        // start held high, n scrambled every cycle: each acceptance uses the
        // n present on its own accept edge, and DONE does not absorb a start.
        start     = 1'b1;
        got       = 0;
        prev_done = 1'b0;
        for (int c = 0; c < 400 && got < 3; c++) begin
            n_in = NW'($urandom_range(0, 15));
            if (!busy) begin
                model(n_in, r, o);
                sb.push_back('{n: n_in, res: r, ovf: o, lat: latency_of(n_in), acc_cyc: cyc + 1});
            end
            @(negedge clk);
            if (prev_done) checkOutput("held done width", 64'(done), 64'd0);
            prev_done = done;
            if (done) begin
                score_done();
                got++;
            end
        end
        start = 1'b0;
        checkOutput("held completions", 64'(got), 64'd3);
        checkOutput("held scoreboard drained", 64'(sb.size()), 64'd0);
        @(negedge clk);
        checkOutput("held done cleared", 64'(done), 64'd0);
        checkOutput("held idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
